// File: rtl/cnt_arb_pkg.sv
// Shared types and default sizing for the slot-counter arbiter.
package cnt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit above last_gnt, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      idx = IDX_W'((int'(last_gnt) + i) % int'(N_REQ));
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_arbiter.sv
// Round-robin slot arbiter: grants one requester for slot_len cycles (0 means 1),
// then idles one cycle. Define CNT_ARB_EARLY_REL_EN to end a slot when its req drops.
module cnt_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] slot_len,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             slot_done
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_t           state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;
  logic [IDX_W-1:0] last_gnt, last_n;
  logic [WIDTH-1:0] l_eff, len_n;

  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             last_cycle;
  logic             early;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .winner   (pick),
    .valid    (pick_valid)
  );

  // One-hot winner to index for the round-robin pointer
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign last_cycle = (count == l_eff - WIDTH'(1));

`ifdef CNT_ARB_EARLY_REL_EN
  assign early = ~|(req & gnt);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    count_n = count;
    done_n  = 1'b0;
    last_n  = last_gnt;
    len_n   = l_eff;
    case (state)
      IDLE: begin
        gnt_n   = '0;
        count_n = '0;
        if (pick_valid) begin
          state_n = RUN;
          gnt_n   = pick;
          last_n  = pick_idx;
          len_n   = (slot_len == '0) ? WIDTH'(1) : slot_len;
          done_n  = (len_n == WIDTH'(1));
        end
      end
      RUN: begin
        if (last_cycle || early) begin
          state_n = IDLE;
          gnt_n   = '0;
          count_n = '0;
        end else begin
          count_n = count + WIDTH'(1);
          done_n  = (count_n == l_eff - WIDTH'(1));
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        count_n = '0;
      end
    endcase
  end

  // State and registered outputs; reset leaves requester 0 with top priority
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      count     <= '0;
      slot_done <= 1'b0;
      last_gnt  <= IDX_W'(N_REQ - 1);
      l_eff     <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      busy      <= |gnt_n;
      count     <= count_n;
      slot_done <= done_n;
      last_gnt  <= last_n;
      l_eff     <= len_n;
    end
  end

endmodule

// File: tb/tb_cnt_arbiter.sv
// Self-checking bench for cnt_arbiter: directed scenarios plus randomized traffic
// against a slot-level reference model; a second WIDTH=4 instance covers the max slot.
module tb_cnt_arbiter;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] slot_len = '0;
  logic [3:0] gnt;
  logic       busy;
  logic [7:0] count;
  logic       slot_done;

  logic [3:0] req_b = '0;
  logic [3:0] slot_len_b = '0;
  logic [3:0] gnt_b;
  logic       busy_b;
  logic [3:0] count_b;
  logic       slot_done_b;

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  cnt_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .slot_len  (slot_len),
    .gnt       (gnt),
    .busy      (busy),
    .count     (count),
    .slot_done (slot_done)
  );

  cnt_arbiter #(.N_REQ(4), .WIDTH(4)) dut_w4 (
    .clock     (clock),
    .reset     (reset),
    .req       (req_b),
    .slot_len  (slot_len_b),
    .gnt       (gnt_b),
    .busy      (busy_b),
    .count     (count_b),
    .slot_done (slot_done_b)
  );

  always #5 clock = ~clock;

  // Reference model: which requester owns the slot, how long, how far along
  int m_owner = -1;
  int m_len   = 0;
  int m_pos   = 0;
  int m_last  = N - 1;
  bit m_done  = 1'b0;

  function automatic int rr(input logic [3:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit released(input logic [3:0] r, input int owner);
`ifdef CNT_ARB_EARLY_REL_EN
    return (r[owner] == 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_owner <= -1;
      m_len   <= 0;
      m_pos   <= 0;
      m_last  <= N - 1;
      m_done  <= 1'b0;
    end else if (m_owner < 0) begin
      m_done <= 1'b0;
      if (rr(req, m_last) >= 0) begin
        m_owner <= rr(req, m_last);
        m_last  <= rr(req, m_last);
        m_len   <= (slot_len == 0) ? 1 : int'(slot_len);
        m_pos   <= 0;
        m_done  <= (slot_len <= 8'd1);
      end
    end else if (m_pos + 1 == m_len || released(req, m_owner)) begin
      m_owner <= -1;
      m_pos   <= 0;
      m_done  <= 1'b0;
    end else begin
      m_pos  <= m_pos + 1;
      m_done <= (m_pos + 2 == m_len);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Advance one cycle and compare the main instance against the model
  task automatic tick();
    @(negedge clock);
    check("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("count", 32'(count), 32'(m_pos));
    check("slot_done", 32'(slot_done), 32'(m_done));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    phase = "reset";
    req = '0;
    slot_len = '0;
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b0;

    // req0 with a 3-cycle slot, then one idle bubble, then a fresh grant
    phase = "len3";
    req = 4'b0001;
    slot_len = 8'd3;
    tick(); check("d_gnt0", 32'(gnt), 32'h1); check("d_cnt0", 32'(count), 32'd0);
    tick(); check("d_cnt1", 32'(count), 32'd1); check("d_done1", 32'(slot_done), 32'd0);
    tick(); check("d_cnt2", 32'(count), 32'd2); check("d_done2", 32'(slot_done), 32'd1);
    tick(); check("d_bubble", 32'(gnt), 32'h0);
    tick(); check("d_regrant", 32'(gnt), 32'h1);

    // All requesting, unit slots: order 0,1,2,3,0 with bubbles between
    phase = "rr";
    req = '0;
    do_reset();
    req = 4'b1111;
    slot_len = 8'd1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i % 2 == 0) begin
        check("rr_gnt", 32'(gnt), 32'd1 << ((i / 2) % 4));
        check("rr_done", 32'(slot_done), 32'd1);
      end else begin
        check("rr_idle", 32'(gnt), 32'd0);
      end
    end

    // Zero length behaves as a single cycle
    phase = "len0";
    req = '0;
    do_reset();
    req = 4'b0100;
    slot_len = 8'd0;
    tick(); check("z_gnt", 32'(gnt), 32'h4); check("z_done", 32'(slot_done), 32'd1);
    check("z_cnt", 32'(count), 32'd0);
    req = '0;
    tick(); check("z_end", 32'(gnt), 32'h0);

    // Drop req[1] while count==2 in a 5-cycle slot
    phase = "drop";
    do_reset();
    req = 4'b0010;
    slot_len = 8'd5;
    tick(); tick(); tick();
    check("r_cnt2", 32'(count), 32'd2);
    req = 4'b0000;
    tick();
`ifdef CNT_ARB_EARLY_REL_EN
    check("r_rel", 32'(gnt), 32'h0);
`else
    check("r_hold", 32'(gnt), 32'h2);
    tick();
    check("r_done", 32'(slot_done), 32'd1);
`endif
    tick(); tick();

    // Asynchronous reset in the middle of a slot
    phase = "async";
    do_reset();
    req = 4'b0001;
    slot_len = 8'd8;
    tick(); tick(); tick(); tick();
    check("a_cnt3", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("a_gnt", 32'(gnt), 32'h0);
    check("a_busy", 32'(busy), 32'd0);
    check("a_cnt", 32'(count), 32'd0);
    tick();
    reset = 1'b0;
    req = 4'b1010;
    tick();
    check("a_first", 32'(gnt), 32'h2);
    req = '0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();

    // Randomized traffic, occasional reset
    phase = "rand";
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) slot_len = 8'($urandom_range(0, 40));
      else slot_len = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
      tick();
      reset = 1'b0;
    end

    // WIDTH=4 instance: longest slot reaches count 14 without wrapping
    phase = "w4";
    req = '0;
    do_reset();
    req_b = 4'b0001;
    slot_len_b = 4'd15;
    for (int k = 0; k < 15; k++) begin
      tick();
      check("w4_gnt", 32'(gnt_b), 32'h1);
      check("w4_cnt", 32'(count_b), 32'(k));
      check("w4_done", 32'(slot_done_b), 32'(k == 14));
    end
    req_b = '0;
    tick();
    check("w4_end", 32'(gnt_b), 32'h0);
    check("w4_cnt_end", 32'(count_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
